// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the seven-segment scan path
package seg_pkg;
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'hF;
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - control/status bundle between scan controller and its host
interface seg_scan_if;
    import seg_pkg::*;

    logic                  en;
    logic [NUM_DIGITS-1:0] digit_mask;
    logic [SEL_W-1:0]      S;
    logic [NUM_DIGITS-1:0] AN;
    logic                  blank;
    logic                  scan_tick;

    modport master (output en, digit_mask, input S, AN, blank, scan_tick);
    modport slave  (input en, digit_mask, output S, AN, blank, scan_tick);
endinterface

// File: rtl/seg_scan_ctrl_slot_timer.sv
// rtl/seg_scan_ctrl_slot_timer.sv - per-slot cycle counter with blank-end and slot-end flags
module slot_timer #(
    parameter int SLOT_CYC  = 100000,
    parameter int BLANK_CYC = 1000,
    parameter int CNT_W     = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic blank_last,
    output logic slot_last
);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(SLOT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // With no dead time the blank-end flag must never fire.
    assign blank_last = (BLANK_CYC > 0) && (cnt == BLANK_END);
    assign slot_last  = (cnt == SLOT_END);
endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - digit scan FSM driving mux select and active-low anodes
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SLOT_CYC  = 100000,
    parameter int BLANK_CYC = 1000,
    parameter int CNT_W     = 17
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);
    state_t                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  blank_q;
    logic                  tick_q, tick_d;
    logic                  clr;
    logic                  blank_last;
    logic                  slot_last;

    slot_timer #(
        .SLOT_CYC  (SLOT_CYC),
        .BLANK_CYC (BLANK_CYC),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .blank_last (blank_last),
        .slot_last  (slot_last)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;
        an_d    = AN_OFF;
        if (!bus.en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = (BLANK_CYC == 0) ? SHOW : BLANK;
                BLANK:   if (blank_last) state_d = SHOW;
                SHOW: begin
                    if (slot_last) begin
                        sel_d   = sel_q + 1'b1;
                        tick_d  = 1'b1;
                        state_d = (BLANK_CYC == 0) ? SHOW : BLANK;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Anodes follow the upcoming state so they switch on the same edge as S.
        if (state_d == SHOW && bus.digit_mask[sel_d]) begin
            an_d = ~(4'b0001 << sel_d);
        end
        clr = !bus.en || (state_q == IDLE) || (state_q == SHOW && slot_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            an_q    <= AN_OFF;
            blank_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            blank_q <= (an_d == AN_OFF);
            tick_q  <= tick_d;
        end
    end

    assign bus.S         = sel_q;
    assign bus.AN        = an_q;
    assign bus.blank     = blank_q;
    assign bus.scan_tick = tick_q;
endmodule
